dp_ram_pipe: RTL
================

# dp_ram_pipe

Parameterised successor to the team's dual-port RAM for the GPGPU memory subsystem. Two independent read/write ports share one DEPTH x DATA_WIDTH array. The block adds:
- per-byte write enables;
- configurable read pipeline latency;
- selectable cross-port read-during-write behaviour;
- a collision flag;
- an optional post-reset zero-initialisation sequencer.

It sits behind the register file and shared-memory arbiters, as the timing-friendly replacement for the single-cycle dual-port RAM.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- DEPTH, 256, number of words
- ADDR_WIDTH, $clog2(DEPTH), address width
- READ_LATENCY, 1, cycles from accepted read to rvalid/rdata; legal 1..4
- RDW_MODE, 0, cross-port same-address read-during-write: 0 = old data, 1 = new (merged) data
- INIT_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no init

Ports (x = a, b):
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- en_x  in  1  port request
- we_x  in  1  1 = write, 0 = read (when en_x)
- be_x  in  NB  byte write enables (writes only)
- addr_x  in  ADDR_WIDTH  word address
- wdata_x  in  DATA_WIDTH  write data
- rvalid_x  out  1  read data valid, one-cycle pulse per read
- rdata_x  out  DATA_WIDTH  read data; holds last value when rvalid_x = 0
- init_busy  out  1  initialisation in progress; requests ignored
- collision  out  1  one-cycle pulse: both ports wrote the same address

## Operation
- **FSM states:** INIT and RUN.
  - Reset enters INIT if INIT_ON_RESET = 1, else RUN.
  - INIT → RUN on the edge that writes address DEPTH-1.
  - RUN stays in RUN until reset.
- **INIT:**
  - Each non-reset cycle writes zero to ram[init_cnt], then increments init_cnt (starting at 0).
  - init_busy = 1 throughout INIT.
  - All port requests are dropped: no write, no rvalid.
- **Request acceptance:** a request is accepted in RUN when en_x = 1.
  - Read = en_x & ~we_x.
  - Write = en_x & we_x. Only bytes with be_x[i] = 1 are updated; be_x = 0 is a no-op write.
- **Write-write collision** (both ports write the same address in the same cycle):
  - Per byte, A wins where be_a[i] = 1; B's byte is written where be_a[i] = 0 and be_b[i] = 1.
  - collision pulses when both write the same address, regardless of byte overlap.
- **Read-read** to the same address: both ports return the same data.
- **Cross-port read-during-write** (port x reads address W while port y writes W):
  - RDW_MODE = 0: return the pre-write word.
  - RDW_MODE = 1: return the post-write merged word, including A/B byte priority.
- A write never produces rvalid on its own port.

## Timing
- **Reset values:** rvalid_a/b = 0, rdata_a/b = 0, collision = 0, init_busy = INIT_ON_RESET, init_cnt = 0, read pipelines flushed.
- **Init timing:** init_busy stays high for exactly DEPTH cycles after reset deasserts; the first request is accepted in the cycle init_busy reads 0.
- **Write timing:** a write is visible to a read accepted in any later cycle.
- **Read latency:** a read accepted at edge N yields rvalid_x = 1 with its data at edge N+READ_LATENCY.
  - Throughput is one read per port per cycle.
  - Back-to-back reads produce back-to-back rvalid pulses in issue order.
- **collision timing:** registered; asserted at the edge after the colliding write cycle, for one cycle.
- **Reset mid-operation:**
  - Reset during INIT restarts at address 0 and the full DEPTH-cycle sequence repeats.
  - In-flight reads are discarded and no rvalid is emitted for them.
  - Array contents are not cleared by reset itself, only by INIT.
- **Address range:** addresses wrap modulo 2^ADDR_WIDTH. For non-power-of-two DEPTH, addresses ≥ DEPTH give undefined rdata; writes to them are dropped.

## Test plan
- **Init:** INIT_ON_RESET = 1, DEPTH = 256; release reset.
  - init_busy is high for 256 cycles.
  - A read issued during busy gives no rvalid.
  - A read of address 0xFF after busy returns 0.
- **Basic write/read:** A writes 0xDEADBEEF, be = 0xF, to address 0x10; B then writes be = 0x3 data 0x00001234 to 0x10; A reads 0x10.
  - After READ_LATENCY = 3, rvalid_a = 1 and rdata_a = 0xDEAD1234.
- **Write collision:** both ports write 0x20 in the same cycle, A = 0x11111111 with be = 0x5, B = 0x22222222 with be = 0xF.
  - collision pulses one cycle later.
  - A subsequent read returns 0x22112211.
- **Read-during-write:** address 0x30 holds 0xAAAA0000; B writes 0x5555FFFF there while A reads 0x30 in the same cycle.
  - RDW_MODE = 0: rdata_a = 0xAAAA0000.
  - RDW_MODE = 1: rdata_a = 0x5555FFFF.
- **Pipeline flush:** 4 back-to-back reads on both ports with READ_LATENCY = 4, reset asserted on the 2nd cycle after issue.
  - No rvalid follows reset.
  - rdata = 0.
  - init_busy reasserts.
- **Throughput:** continuous reads of addresses 0..15 on A, interleaved with writes on B.
  - 16 consecutive rvalid_a pulses with in-order data.

Source files
------------

// File: rtl/dp_ram_pipe.sv
// Dual-port DEPTH x DATA_WIDTH RAM with byte enables, a configurable read pipeline,
// selectable cross-port read-during-write data, a write-collision flag and post-reset zeroing.
module dp_ram_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int DEPTH         = 256,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int READ_LATENCY  = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en_a,
  input  logic                             we_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            wdata_a,
  output logic                             rvalid_a,
  output logic [DATA_WIDTH-1:0]            rdata_a,
  input  logic                             en_b,
  input  logic                             we_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            wdata_b,
  output logic                             rvalid_b,
  output logic [DATA_WIDTH-1:0]            rdata_b,
  output logic                             init_busy,
  output logic                             collision
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    run;
  logic                    wr_a;
  logic                    wr_b;
  logic [1:0]              rd_en;
  logic [DATA_WIDTH-1:0]   rd_word [2];

  logic [READ_LATENCY-1:0] vld_p   [2];
  logic [DATA_WIDTH-1:0]   data_p  [2][READ_LATENCY];
  logic                    rvalid_q [2];
  logic [DATA_WIDTH-1:0]   rdata_q  [2];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  // Word at addr after this cycle's writes; A owns every byte it enables.
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  wa,
    input logic [ADDR_WIDTH-1:0] aa,
    input logic [NB-1:0]         ba,
    input logic [DATA_WIDTH-1:0] da,
    input logic                  wb,
    input logic [ADDR_WIDTH-1:0] ab,
    input logic [NB-1:0]         bb,
    input logic [DATA_WIDTH-1:0] db
  );
    logic [DATA_WIDTH-1:0] w;
    w = old;
    for (int i = 0; i < NB; i++) begin
      if (wa && aa == addr && ba[i])
        w[i*BYTE_WIDTH +: BYTE_WIDTH] = da[i*BYTE_WIDTH +: BYTE_WIDTH];
      else if (wb && ab == addr && bb[i])
        w[i*BYTE_WIDTH +: BYTE_WIDTH] = db[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return w;
  endfunction

  assign run      = (state == RUN) && !reset;
  assign wr_a     = run && en_a && we_a && in_range(addr_a);
  assign wr_b     = run && en_b && we_b && in_range(addr_b);
  assign rd_en[0] = run && en_a && !we_a;
  assign rd_en[1] = run && en_b && !we_b;

  always_comb begin
    rd_word[0] = mem[addr_a];
    rd_word[1] = mem[addr_b];
    if (RDW_MODE != 0) begin
      rd_word[0] = merge_word(mem[addr_a], addr_a, wr_a, addr_a, be_a, wdata_a,
                              wr_b, addr_b, be_b, wdata_b);
      rd_word[1] = merge_word(mem[addr_b], addr_b, wr_a, addr_a, be_a, wdata_a,
                              wr_b, addr_b, be_b, wdata_b);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[init_cnt] <= '0;
      end else begin
        if (wr_a)
          mem[addr_a] <= merge_word(mem[addr_a], addr_a, wr_a, addr_a, be_a, wdata_a,
                                    wr_b, addr_b, be_b, wdata_b);
        if (wr_b)
          mem[addr_b] <= merge_word(mem[addr_b], addr_b, wr_a, addr_a, be_a, wdata_a,
                                    wr_b, addr_b, be_b, wdata_b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (INIT_ON_RESET != 0) ? INIT : RUN;
      init_cnt  <= '0;
      collision <= 1'b0;
    end else begin
      collision <= wr_a && wr_b && (addr_a == addr_b);
      if (state == INIT) begin
        init_cnt <= init_cnt + ADDR_WIDTH'(1);
        if (init_cnt == ADDR_WIDTH'(DEPTH - 1))
          state <= RUN;
      end
    end
  end

  assign init_busy = (state == INIT);

  // Stage p0 captures the read word at the accepting edge; later stages only delay it.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      data_p[p][0] <= rd_word[p];
      for (int k = 1; k < READ_LATENCY; k++)
        data_p[p][k] <= data_p[p][k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset)
        vld_p[p] <= '0;
      else
        vld_p[p] <= (vld_p[p] << 1) | READ_LATENCY'(rd_en[p]);
    end
  end

  // Output stage: rdata holds its last value between read pulses.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        rvalid_q[p] <= 1'b0;
        rdata_q[p]  <= '0;
      end else begin
        rvalid_q[p] <= vld_p[p][READ_LATENCY-1];
        if (vld_p[p][READ_LATENCY-1])
          rdata_q[p] <= data_p[p][READ_LATENCY-1];
      end
    end
  end

  assign rvalid_a = rvalid_q[0];
  assign rdata_a  = rdata_q[0];
  assign rvalid_b = rvalid_q[1];
  assign rdata_b  = rdata_q[1];

endmodule
